// File: rtl/pr_seq_pkg.sv
// Shared types and constants for the partial-reconfiguration sequencer.
package pr_seq_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    PR_IDLE      = 3'd0,
    PR_FREEZE    = 3'd1,
    PR_REQUEST   = 3'd2,
    PR_STREAM    = 3'd3,
    PR_WAIT_DONE = 3'd4,
    PR_UNFREEZE  = 3'd5,
    PR_DONE      = 3'd6,
    PR_ERROR     = 3'd7
  } pr_state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PR      = 3'd1;
  localparam logic [2:0] ERR_REQ_TO  = 3'd2;
  localparam logic [2:0] ERR_DONE_TO = 3'd3;
  localparam logic [2:0] ERR_CRC     = 3'd4;

  // States in which the PR block is being talked to and pr_clk runs.
  function automatic logic pr_link_active(input pr_state_t s);
    return (s == PR_REQUEST) || (s == PR_STREAM) || (s == PR_WAIT_DONE);
  endfunction

endpackage

// File: rtl/pr_sequencer_if.sv
// Bitstream-source and PR hard-block signals seen by pr_sequencer.
interface pr_sequencer_if;
  import pr_seq_pkg::*;

  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_last;
  logic              bs_ready;
  logic              pr_request;
  logic [WORD_W-1:0] pr_data;
  logic              pr_clk;
  logic              pr_ready;
  logic              pr_done;
  logic              pr_error;

  modport master (
    input  bs_data, bs_valid, bs_last, pr_ready, pr_done, pr_error,
    output bs_ready, pr_request, pr_data, pr_clk
  );

  modport slave (
    output bs_data, bs_valid, bs_last, pr_ready, pr_done, pr_error,
    input  bs_ready, pr_request, pr_data, pr_clk
  );
endinterface

// File: rtl/pr_sync.sv
// Two-flop synchroniser for asynchronous level inputs, cleared to zero on reset.
module pr_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pr_sequencer.sv
// Sequences one PR transaction: freeze, request, stream, wait for done/error, release.
// Optional PR_TIMEOUT_EN adds a timeout in REQUEST and WAIT_DONE.
module pr_sequencer
  import pr_seq_pkg::*;
#(
  parameter int FREEZE_CYCLES  = 16,
  parameter int RELEASE_CYCLES = 16
`ifdef PR_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           clear,
  input  logic           crc_error,
  pr_sequencer_if.master bus,
  output logic           freeze,
  output logic           busy,
  output logic           status_done,
  output logic           status_error,
  output logic [2:0]     err_code
);

  localparam int CNT_W = 21;
  localparam logic [CNT_W-1:0] FREEZE_LAST  = CNT_W'(FREEZE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
`ifdef PR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  pr_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_run;
  logic [2:0]        err_code_q, err_code_d;
  logic [WORD_W-1:0] pr_data_q, pr_data_d;
  logic              bs_ready_q, bs_ready_d;
  logic              pr_clk_q, pr_clk_d;
  logic              pr_request_q, pr_request_d;
  logic              freeze_q, freeze_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [2:0]        sync_s;
  logic              ready_s, done_s, error_s;

  pr_sync #(.WIDTH(3)) u_sync (
    .clk     (clk),
    .rst     (reset),
    .async_i ({bus.pr_error, bus.pr_done, bus.pr_ready}),
    .sync_o  (sync_s)
  );

  assign ready_s = sync_s[0];
  assign done_s  = sync_s[1];
  assign error_s = sync_s[2];

  // Next state, phase counter, error code and the bitstream word slot.
  always_comb begin
    state_d    = state_q;
    cnt_run    = cnt_q;
    err_code_d = err_code_q;
    pr_data_d  = pr_data_q;
    bs_ready_d = 1'b0;
    case (state_q)
      PR_IDLE: begin
        if (start && crc_error) begin
          state_d    = PR_ERROR;
          err_code_d = ERR_CRC;
        end else if (start) begin
          state_d    = PR_FREEZE;
          err_code_d = ERR_NONE;
        end else begin
          state_d = PR_IDLE;
        end
      end
      PR_FREEZE: begin
        if (cnt_q == FREEZE_LAST) begin
          state_d = PR_REQUEST;
        end else begin
          cnt_run = cnt_q + 21'd1;
        end
      end
      PR_REQUEST: begin
        if (error_s) begin
          state_d    = PR_ERROR;
          err_code_d = ERR_PR;
        end else if (ready_s) begin
          state_d = PR_STREAM;
`ifdef PR_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = PR_ERROR;
          err_code_d = ERR_REQ_TO;
        end else begin
          cnt_run = cnt_q + 21'd1;
`else
        end else begin
          state_d = PR_REQUEST;
`endif
        end
      end
      PR_STREAM: begin
        // Words move only on the step where pr_clk falls, so pr_data is stable at every pr_clk rise.
        if (error_s) begin
          state_d    = PR_ERROR;
          err_code_d = ERR_PR;
        end else if (pr_clk_q && bus.bs_valid) begin
          pr_data_d  = bus.bs_data;
          bs_ready_d = 1'b1;
          state_d    = bus.bs_last ? PR_WAIT_DONE : PR_STREAM;
        end else begin
          state_d = PR_STREAM;
        end
      end
      PR_WAIT_DONE: begin
        if (error_s) begin
          state_d    = PR_ERROR;
          err_code_d = ERR_PR;
        end else if (done_s) begin
          state_d = PR_UNFREEZE;
`ifdef PR_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = PR_ERROR;
          err_code_d = ERR_DONE_TO;
        end else begin
          cnt_run = cnt_q + 21'd1;
`else
        end else begin
          state_d = PR_WAIT_DONE;
`endif
        end
      end
      PR_UNFREEZE: begin
        // The release count only starts once the block has dropped pr_ready.
        if ((cnt_q == {CNT_W{1'b0}}) && ready_s) begin
          state_d = PR_UNFREEZE;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = PR_DONE;
        end else begin
          cnt_run = cnt_q + 21'd1;
        end
      end
      PR_DONE: begin
        state_d = clear ? PR_IDLE : PR_DONE;
      end
      PR_ERROR: begin
        if (clear) begin
          state_d    = PR_IDLE;
          err_code_d = ERR_NONE;
        end else begin
          state_d = PR_ERROR;
        end
      end
      default: begin
        state_d = PR_IDLE;
      end
    endcase
    cnt_d = (state_d == state_q) ? cnt_run : {CNT_W{1'b0}};
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin
    pr_clk_d     = pr_link_active(state_d) ? ~pr_clk_q : 1'b0;
    pr_request_d = pr_link_active(state_d);
    busy_d       = (state_d != PR_IDLE) && (state_d != PR_DONE) && (state_d != PR_ERROR);
    done_d       = (state_d == PR_DONE);
    error_d      = (state_d == PR_ERROR);
    case (state_d)
      PR_IDLE:  freeze_d = 1'b0;
      PR_DONE:  freeze_d = 1'b0;
      PR_ERROR: freeze_d = freeze_q;
      default:  freeze_d = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PR_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      err_code_q   <= ERR_NONE;
      pr_data_q    <= 16'h0000;
      bs_ready_q   <= 1'b0;
      pr_clk_q     <= 1'b0;
      pr_request_q <= 1'b0;
      freeze_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_code_q   <= err_code_d;
      pr_data_q    <= pr_data_d;
      bs_ready_q   <= bs_ready_d;
      pr_clk_q     <= pr_clk_d;
      pr_request_q <= pr_request_d;
      freeze_q     <= freeze_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.bs_ready   = bs_ready_q;
  assign bus.pr_data    = pr_data_q;
  assign bus.pr_clk     = pr_clk_q;
  assign bus.pr_request = pr_request_q;
  assign freeze         = freeze_q;
  assign busy           = busy_q;
  assign status_done    = done_q;
  assign status_error   = error_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_pr_sequencer.sv
// Table-driven bench for pr_sequencer with a bitstream source, a PR-block model and a word scoreboard.
`timescale 1ns/1ps
module tb_pr_sequencer;
  import pr_seq_pkg::*;

  localparam int FREEZE_N  = 16;
  localparam int RELEASE_N = 16;
  localparam int TO_N      = 64;

  typedef struct {
    bit         crc;
    int         n_words;
    int         stall_after;
    int         err_after;
    int         abort_after;
    bit         never_ready;
    bit         poke;
    bit         exp_done;
    bit         exp_error;
    logic [2:0] exp_code;
    int         exp_words;
    bit         exp_freeze_end;
    bit         exp_active;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start, clear, crc_error;
  logic       freeze, busy, status_done, status_error;
  logic [2:0] err_code;

  pr_sequencer_if bus();

  pr_sequencer #(
    .FREEZE_CYCLES  (FREEZE_N),
    .RELEASE_CYCLES (RELEASE_N)
`ifdef PR_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO_N)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .clear        (clear),
    .crc_error    (crc_error),
    .bus          (bus),
    .freeze       (freeze),
    .busy         (busy),
    .status_done  (status_done),
    .status_error (status_error),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[$];
  vec_t cur;
  logic [15:0] exp_q[$];
  int cyc, m_rises, m_xfers, m_done_cnt, src_idx, pushed_idx, stall_left;
  int pr_activity, freeze_viol, data_spur;
  int freeze_rise_cyc, req_rise_cyc, req_fall_cyc, freeze_fall_cyc;
  logic prev_pr_clk, prev_req, prev_freeze, prev_xfer;
  logic [15:0] prev_pr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clk: update source and PR model, then observe the DUT just after the edge.
  task automatic step();
    logic [15:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_xfer) begin
      src_idx++;
      if (src_idx == cur.stall_after) stall_left = 6;
    end else if (stall_left > 0) begin
      stall_left--;
    end
    bus.bs_valid = (src_idx < cur.n_words) && (stall_left == 0);
    bus.bs_data  = 16'hA5A5 + 16'(src_idx);
    bus.bs_last  = (src_idx == cur.n_words - 1);
    if (bus.bs_valid && src_idx != pushed_idx) begin
      exp_q.push_back(bus.bs_data);
      pushed_idx = src_idx;
    end

    prev_xfer = bus.bs_valid && bus.bs_ready;
    if (bus.bs_ready) begin
      m_xfers++;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'(bus.pr_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pr_data_word", 32'(bus.pr_data), 32'(e));
      end
    end
    if (bus.pr_data !== prev_pr_data && !bus.bs_ready) data_spur++;
    if ((bus.pr_request || bus.pr_clk || bus.bs_ready) && !freeze) freeze_viol++;
    if (bus.pr_clk && !prev_pr_clk) begin
      pr_activity++;
      if (bus.pr_request) m_rises++;
    end
    if (bus.pr_request && !prev_req) begin
      pr_activity++;
      req_rise_cyc = cyc;
    end
    if (!bus.pr_request && prev_req) req_fall_cyc = cyc;
    if (freeze && !prev_freeze) freeze_rise_cyc = cyc;
    if (!freeze && prev_freeze) freeze_fall_cyc = cyc;

    if (bus.pr_request) begin
      if (!cur.never_ready && m_rises >= 5) bus.pr_ready = 1'b1;
      if (cur.err_after > 0 && m_xfers >= cur.err_after) bus.pr_error = 1'b1;
      if (cur.err_after == 0 && m_xfers >= cur.n_words) begin
        m_done_cnt++;
        if (m_done_cnt >= 4) bus.pr_done = 1'b1;
      end
    end else begin
      bus.pr_ready = 1'b0;
      bus.pr_done  = 1'b0;
      bus.pr_error = 1'b0;
    end

    prev_pr_clk  = bus.pr_clk;
    prev_req     = bus.pr_request;
    prev_freeze  = freeze;
    prev_pr_data = bus.pr_data;
  endtask

  task automatic run_txn(input vec_t v);
    bit aborted;
    cur = v;
    exp_q.delete();
    cyc = 0; m_rises = 0; m_xfers = 0; m_done_cnt = 0;
    src_idx = 0; pushed_idx = -1; stall_left = 0; prev_xfer = 1'b0;
    pr_activity = 0; freeze_viol = 0; data_spur = 0;
    freeze_rise_cyc = 0; req_rise_cyc = 0; req_fall_cyc = 0; freeze_fall_cyc = 0;
    prev_pr_clk = bus.pr_clk; prev_req = bus.pr_request;
    prev_freeze = freeze; prev_pr_data = bus.pr_data;
    aborted = 1'b0;
    crc_error = v.crc;
    start = 1'b1;
    clear = v.poke;
    step();
    start = 1'b0;
    clear = 1'b0;
    if (v.poke) check("start_beats_clear", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3000; i++) begin
      if (status_done || status_error) break;
      if (v.abort_after > 0 && m_xfers >= v.abort_after) begin
        aborted = 1'b1;
        break;
      end
      if (v.poke && i == 3) begin
        start = 1'b1;
        clear = 1'b1;
      end
      step();
      start = 1'b0;
      clear = 1'b0;
      if (v.poke && i == 3) check("start_clear_ignored_busy", {29'd0, busy, status_done, status_error}, 32'd4);
    end
    crc_error = 1'b0;

    if (aborted) begin
      #3 reset = 1'b1;
      #1;
      check("async_reset_outputs",
            {6'd0, freeze, busy, status_done, status_error, err_code,
             bus.pr_request, bus.pr_clk, bus.bs_ready, bus.pr_data}, 32'd0);
      bus.bs_valid = 1'b0;
      bus.pr_ready = 1'b0;
      bus.pr_done  = 1'b0;
      bus.pr_error = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      return;
    end

    if (!(status_done || status_error)) check("txn_finished", 32'd0, 32'd1);
    if (v.exp_code == ERR_REQ_TO) check("request_timeout_cycles", 32'(cyc - req_rise_cyc), 32'(TO_N));
    repeat (4) step();
    check("status_done", {31'd0, status_done}, {31'd0, v.exp_done});
    check("status_error", {31'd0, status_error}, {31'd0, v.exp_error});
    check("err_code", {29'd0, err_code}, {29'd0, v.exp_code});
    check("words_delivered", 32'(m_xfers), 32'(v.exp_words));
    check("freeze_at_end", {31'd0, freeze}, {31'd0, v.exp_freeze_end});
    check("pr_request_low_at_end", {31'd0, bus.pr_request}, 32'd0);
    check("pr_link_activity", {31'd0, (pr_activity != 0)}, {31'd0, v.exp_active});
    check("freeze_held_while_active", 32'(freeze_viol), 32'd0);
    check("pr_data_held_between_words", 32'(data_spur), 32'd0);
    if (v.exp_done) begin
      check("freeze_to_request_cycles", 32'(req_rise_cyc - freeze_rise_cyc), 32'(FREEZE_N));
      check("release_cycles", 32'(freeze_fall_cyc - req_fall_cyc), 32'(RELEASE_N + 2));
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    check("after_clear_idle", {26'd0, freeze, busy, status_done, status_error, err_code}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary, expected one");
    $fatal(1);
  end

  initial begin
    vec_t v_abort;
    //                 crc   nw stall err abrt nrdy  poke  done  err   code         nw frz   act
    vecs.push_back('{1'b0, 4, -1,   0,  0,  1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE,    4, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4,  2,   0,  0,  1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE,    4, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4, -1,   2,  0,  1'b0, 1'b0, 1'b0, 1'b1, ERR_PR,      3, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 4, -1,   0,  0,  1'b0, 1'b0, 1'b0, 1'b1, ERR_CRC,     0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4, -1,   0,  0,  1'b0, 1'b1, 1'b1, 1'b0, ERR_NONE,    4, 1'b0, 1'b1});
`ifdef PR_TIMEOUT_EN
    vecs.push_back('{1'b0, 4, -1,   0,  0,  1'b1, 1'b0, 1'b0, 1'b1, ERR_REQ_TO,  0, 1'b1, 1'b1});
`endif
    v_abort = '{1'b0, 4, -1, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, ERR_NONE, 0, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; clear = 1'b0; crc_error = 1'b0;
    bus.bs_data = 16'h0000; bus.bs_valid = 1'b0; bus.bs_last = 1'b0;
    bus.pr_ready = 1'b0; bus.pr_done = 1'b0; bus.pr_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {6'd0, freeze, busy, status_done, status_error, err_code,
           bus.pr_request, bus.pr_clk, bus.bs_ready, bus.pr_data}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_outputs_after_reset",
          {6'd0, freeze, busy, status_done, status_error, err_code,
           bus.pr_request, bus.pr_clk, bus.bs_ready, bus.pr_data}, 32'd0);

    foreach (vecs[i]) run_txn(vecs[i]);

    run_txn(v_abort);
    run_txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
